// File: rtl/ysyx_23060208_ifu_pf_if.sv
// AXI4 single-beat read channel between the prefetching IFU (master)
// and the instruction SRAM / arbiter (slave).
interface ysyx_23060208_ifu_pf_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arid;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [3:0]            rid;

    modport master (
        output araddr, arvalid, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  araddr, arvalid, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060208_ifu_pf.sv
// Prefetching IFU: sequential single-beat AXI reads into a QDEPTH-entry queue,
// redirect flush with stale-response drop. Optional YSYX_23060208_IFU_BYPASS_EN.
module ysyx_23060208_ifu_pf #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    QDEPTH     = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000,
    parameter logic [3:0]            AXI_ID     = 4'h1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    ysyx_23060208_ifu_pf_if.master isram,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_fault
);
    localparam int            AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0]   QD = (AW + 1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] fetch_pc, araddr_q;
    logic [AW-1:0]         head, tail;
    logic [AW:0]           count, count_nxt;
    logic                  halt, drop, load_ar;

    logic [DATA_WIDTH-1:0] q_pc   [QDEPTH];
    logic [DATA_WIDTH-1:0] q_inst [QDEPTH];
    logic                  q_fault[QDEPTH];

    logic ar_hs, r_ok, beat_keep, beat_fault, q_nonempty, byp, push, pop;
    logic unused_rlast;

    assign isram.araddr  = araddr_q;
    assign isram.arvalid = (state == REQ);
    assign isram.arlen   = 8'd0;
    assign isram.arsize  = 3'b010;
    assign isram.arburst = 2'b01;
    assign isram.arid    = AXI_ID;
    assign isram.rready  = (state == RESP);
    assign unused_rlast  = isram.rlast;

    assign ar_hs      = (state == REQ) && isram.arready;
    // Foreign-ID beats are swallowed (rready is high) but never complete the fetch.
    assign r_ok       = (state == RESP) && isram.rvalid && (isram.rid == AXI_ID);
    assign beat_keep  = r_ok && !drop && !redirect_valid;
    assign beat_fault = (isram.rresp != 2'b00);
    assign q_nonempty = (count != '0);
    assign pop        = q_nonempty && inst_ready;

`ifdef YSYX_23060208_IFU_BYPASS_EN
    assign byp        = beat_keep && !q_nonempty && inst_ready;
    assign inst_valid = q_nonempty || byp;
    assign inst_pc    = q_nonempty ? q_pc[head]   : araddr_q;
    assign inst       = q_nonempty ? q_inst[head] : isram.rdata;
    assign inst_fault = q_nonempty ? q_fault[head] : (byp && beat_fault);
`else
    assign byp        = 1'b0;
    assign inst_valid = q_nonempty;
    assign inst_pc    = q_pc[head];
    assign inst       = q_inst[head];
    assign inst_fault = q_nonempty && q_fault[head];
`endif

    assign push      = beat_keep && !byp;
    assign count_nxt = redirect_valid ? '0
                     : count + (AW + 1)'(push) - (AW + 1)'(pop);

    always_comb begin
        state_nxt = state;
        load_ar   = 1'b0;
        case (state)
            IDLE: begin
                // Only one fetch is ever in flight, so count alone bounds occupancy here.
                if (!redirect_valid && !halt && count < QD) begin
                    state_nxt = REQ;
                    load_ar   = 1'b1;
                end
            end
            REQ: begin
                if (isram.arready) state_nxt = RESP;
            end
            RESP: begin
                if (r_ok) begin
                    state_nxt = IDLE;
`ifdef YSYX_23060208_IFU_BYPASS_EN
                    if (beat_keep && !beat_fault && !halt && count_nxt < QD) begin
                        state_nxt = REQ;
                        load_ar   = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            araddr_q <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halt     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (load_ar) araddr_q <= fetch_pc;

            if (redirect_valid)      fetch_pc <= redirect_pc;
            else if (ar_hs && !drop) fetch_pc <= fetch_pc + DATA_WIDTH'(4);

            // A redirect orphans the request being presented or awaited.
            if (redirect_valid && (state == REQ || (state == RESP && !r_ok))) drop <= 1'b1;
            else if (r_ok)                                                    drop <= 1'b0;

            if (redirect_valid)                     halt <= 1'b0;
            else if ((push || byp) && beat_fault)   halt <= 1'b1;

            if (redirect_valid) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop)  head <= head + AW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[tail]    <= araddr_q;
            q_inst[tail]  <= isram.rdata;
            q_fault[tail] <= beat_fault;
        end
    end
endmodule
